// File: rtl/i2c_reader.sv
// I2C master read engine: START, addr(W), pointer, repeated START, addr(R), 1-4 data bytes, STOP.
// One FSM state per PT_CK edge; every output is registered and takes the value for the state being entered.
module i2c_reader (
   input  logic        RESET_N,
   input  logic        PT_CK,
   input  logic        GO,
   input  logic [7:0]  SLAVE_ADDRESS,
   input  logic [7:0]  REG_ADDR,
   input  logic [2:0]  BYTE_NUM,
   input  logic        SDAI,
   output logic        SDAO,
   output logic        SCLO,
   output logic        END_OK,
   output logic        NACK_ERR,
   output logic [31:0] RD_DATA,
   output logic        RD_VALID,
   output logic [7:0]  ST
);

   typedef enum logic [3:0] {
      IDLE, LAUNCH, S0, S1, B0, B1, B2, B3,
      R0, R1, R2, R3, P0, P1, P2, DONE
   } state_t;

   typedef enum logic [1:0] {PH_WADDR, PH_REG, PH_RADDR, PH_DATA} phase_t;

   state_t      state, state_n;
   phase_t      phase, phase_n;
   logic        arm, arm_n;
   logic        sda_n, scl_n, end_ok_n, nack_n, valid_n;
   logic [31:0] data_n;
   logic [7:0]  addr_q, addr_n;
   logic [7:0]  reg_q, reg_n;
   logic [2:0]  nbytes, nbytes_n;
   logic [3:0]  bit_cnt, bit_n;
   logic [2:0]  byte_cnt, byte_n;
   logic [7:0]  rx, rx_n;
   logic [7:0]  tx_byte;
   logic [2:0]  byte_inc;
   logic        last_byte;
   logic        tx_bit;

   function automatic logic [2:0] clamp_bytes(input logic [2:0] n);
      if (n == 3'd0)
         return 3'd1;
      else if (n > 3'd4)
         return 3'd4;
      else
         return n;
   endfunction

   // Bit 0 of the latched address is overwritten by the R/W flag.
   always_comb begin
      case (phase)
         PH_WADDR: tx_byte = addr_q & 8'hFE;
         PH_REG:   tx_byte = reg_q;
         PH_RADDR: tx_byte = addr_q | 8'h01;
         default:  tx_byte = 8'hFF;
      endcase
   end

   assign byte_inc  = byte_cnt + 3'd1;
   assign last_byte = (byte_inc == nbytes);

   // Slot 8 is the ACK slot: released for address/pointer, ACK/NACK for data.
   always_comb begin
      if (bit_cnt == 4'd8)
         tx_bit = (phase == PH_DATA) ? last_byte : 1'b1;
      else if (phase == PH_DATA)
         tx_bit = 1'b1;
      else
         tx_bit = tx_byte[3'(4'd7 - bit_cnt)];
   end

   always_comb begin
      state_n  = state;
      phase_n  = phase;
      arm_n    = arm;
      sda_n    = SDAO;
      scl_n    = SCLO;
      end_ok_n = END_OK;
      nack_n   = NACK_ERR;
      valid_n  = 1'b0;
      data_n   = RD_DATA;
      addr_n   = addr_q;
      reg_n    = reg_q;
      nbytes_n = nbytes;
      bit_n    = bit_cnt;
      byte_n   = byte_cnt;
      rx_n     = rx;
      case (state)
         IDLE: begin
            sda_n = 1'b1;
            scl_n = 1'b1;
            if (arm && !GO) begin
               state_n  = LAUNCH;
               arm_n    = 1'b0;
               end_ok_n = 1'b0;
               nack_n   = 1'b0;
               data_n   = 32'd0;
               addr_n   = SLAVE_ADDRESS;
               reg_n    = REG_ADDR;
               nbytes_n = clamp_bytes(BYTE_NUM);
               phase_n  = PH_WADDR;
               bit_n    = 4'd0;
               byte_n   = 3'd0;
            end else if (GO) begin
               arm_n = 1'b1;
            end
         end
         LAUNCH: begin
            sda_n   = 1'b0;
            state_n = S0;
         end
         S0: begin
            scl_n   = 1'b0;
            state_n = S1;
         end
         S1: state_n = B0;
         B0: begin
            sda_n   = tx_bit;
            state_n = B1;
         end
         B1: begin
            scl_n   = 1'b1;
            state_n = B2;
         end
         B2: state_n = B3;
         B3: begin
            scl_n = 1'b0;
            if (bit_cnt != 4'd8) begin
               bit_n   = bit_cnt + 4'd1;
               state_n = B0;
               if (phase == PH_DATA)
                  rx_n = {rx[6:0], SDAI};
            end else begin
               bit_n = 4'd0;
               if (phase != PH_DATA && SDAI) begin
                  nack_n  = 1'b1;
                  sda_n   = 1'b0;
                  state_n = P0;
               end else begin
                  case (phase)
                     PH_WADDR: begin
                        phase_n = PH_REG;
                        state_n = B0;
                     end
                     PH_REG: begin
                        sda_n   = 1'b1;
                        state_n = R0;
                     end
                     PH_RADDR: begin
                        phase_n = PH_DATA;
                        byte_n  = 3'd0;
                        state_n = B0;
                     end
                     default: begin
                        data_n = {RD_DATA[23:0], rx};
                        byte_n = byte_inc;
                        if (last_byte) begin
                           sda_n   = 1'b0;
                           state_n = P0;
                        end else begin
                           state_n = B0;
                        end
                     end
                  endcase
               end
            end
         end
         R0: begin
            scl_n   = 1'b1;
            state_n = R1;
         end
         R1: begin
            sda_n   = 1'b0;
            state_n = R2;
         end
         R2: begin
            scl_n   = 1'b0;
            state_n = R3;
         end
         R3: begin
            phase_n = PH_RADDR;
            state_n = B0;
         end
         P0: begin
            scl_n   = 1'b1;
            state_n = P1;
         end
         P1: begin
            sda_n   = 1'b1;
            state_n = P2;
         end
         P2: begin
            end_ok_n = 1'b1;
            valid_n  = !NACK_ERR;
            state_n  = DONE;
         end
         DONE: state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge PT_CK or negedge RESET_N) begin
      if (!RESET_N) begin
         state    <= IDLE;
         phase    <= PH_WADDR;
         arm      <= 1'b0;
         SDAO     <= 1'b1;
         SCLO     <= 1'b1;
         END_OK   <= 1'b1;
         NACK_ERR <= 1'b0;
         RD_VALID <= 1'b0;
         RD_DATA  <= 32'd0;
         addr_q   <= 8'd0;
         reg_q    <= 8'd0;
         nbytes   <= 3'd1;
         bit_cnt  <= 4'd0;
         byte_cnt <= 3'd0;
         rx       <= 8'd0;
      end else begin
         state    <= state_n;
         phase    <= phase_n;
         arm      <= arm_n;
         SDAO     <= sda_n;
         SCLO     <= scl_n;
         END_OK   <= end_ok_n;
         NACK_ERR <= nack_n;
         RD_VALID <= valid_n;
         RD_DATA  <= data_n;
         addr_q   <= addr_n;
         reg_q    <= reg_n;
         nbytes   <= nbytes_n;
         bit_cnt  <= bit_n;
         byte_cnt <= byte_n;
         rx       <= rx_n;
      end
   end

   assign ST = {4'd0, state};

endmodule

// File: tb/tb_i2c_reader.sv
// Directed bench for i2c_reader: behavioural I2C slave at 0x39 plus a START/STOP monitor on SDAO/SCLO.
module tb_i2c_reader;

   logic        RESET_N;
   logic        PT_CK = 1'b0;
   logic        GO;
   logic [7:0]  SLAVE_ADDRESS;
   logic [7:0]  REG_ADDR;
   logic [2:0]  BYTE_NUM;
   logic        SDAI;
   logic        SDAO;
   logic        SCLO;
   logic        END_OK;
   logic        NACK_ERR;
   logic [31:0] RD_DATA;
   logic        RD_VALID;
   logic [7:0]  ST;

   i2c_reader dut (
      .RESET_N       (RESET_N),
      .PT_CK         (PT_CK),
      .GO            (GO),
      .SLAVE_ADDRESS (SLAVE_ADDRESS),
      .REG_ADDR      (REG_ADDR),
      .BYTE_NUM      (BYTE_NUM),
      .SDAI          (SDAI),
      .SDAO          (SDAO),
      .SCLO          (SCLO),
      .END_OK        (END_OK),
      .NACK_ERR      (NACK_ERR),
      .RD_DATA       (RD_DATA),
      .RD_VALID      (RD_VALID),
      .ST            (ST)
   );

   always #5 PT_CK = ~PT_CK;

   int n_checks = 0;
   int n_fail   = 0;

   // Slave state
   logic       sl_respond;
   logic [7:0] sl_mem [0:255];
   int         sl_mode = 0;
   int         sl_bits = 0;
   logic [7:0] sl_rx = 8'd0;
   logic [7:0] sl_ptr = 8'd0;
   logic [7:0] sl_tx = 8'd0;
   logic       sl_sda = 1'b1;
   logic       sl_prev_scl = 1'b1;
   logic       sl_prev_line = 1'b1;
   logic       prev_sdao = 1'b1;

   // Cumulative monitor counters; transactions compare deltas against snapshots.
   int          mon_starts = 0;
   int          mon_stops = 0;
   int          mon_low = 0;
   int          mon_valid = 0;
   int          mon_ackcnt = 0;
   logic [31:0] mon_ackbits = 32'd0;
   int          s_starts, s_stops, s_low, s_valid, s_ackcnt;

   assign SDAI = SDAO & sl_sda;

   always @(negedge PT_CK) begin
      if (!RESET_N) begin
         sl_mode <= 0;
         sl_bits <= 0;
         sl_sda  <= 1'b1;
      end else if (sl_prev_scl && SCLO && sl_prev_line && !SDAI) begin
         sl_mode <= 1;
         sl_bits <= 0;
         sl_sda  <= 1'b1;
      end else if (sl_prev_scl && SCLO && !sl_prev_line && SDAI) begin
         sl_mode <= 0;
         sl_bits <= 0;
         sl_sda  <= 1'b1;
      end else if (!sl_prev_scl && SCLO) begin
         if (sl_bits < 8) begin
            sl_rx   <= {sl_rx[6:0], SDAI};
            sl_bits <= sl_bits + 1;
         end else begin
            sl_bits <= 0;
            case (sl_mode)
               1: begin
                  if (sl_respond && sl_rx[7:1] == 7'h39) begin
                     if (sl_rx[0]) begin
                        sl_mode <= 3;
                        sl_tx   <= sl_mem[sl_ptr];
                     end else begin
                        sl_mode <= 2;
                     end
                  end else begin
                     sl_mode <= 0;
                  end
               end
               2: begin
                  sl_ptr  <= sl_rx;
                  sl_mode <= 0;
               end
               3: begin
                  mon_ackbits <= {mon_ackbits[30:0], SDAO};
                  mon_ackcnt  <= mon_ackcnt + 1;
                  if (!SDAI) begin
                     sl_ptr <= sl_ptr + 8'd1;
                     sl_tx  <= sl_mem[sl_ptr + 8'd1];
                  end else begin
                     sl_mode <= 0;
                  end
               end
               default: ;
            endcase
         end
      end else if (sl_prev_scl && !SCLO) begin
         if (sl_mode == 3)
            sl_sda <= (sl_bits < 8) ? sl_tx[3'(7 - sl_bits)] : 1'b1;
         else if (sl_mode == 1 && sl_bits == 8)
            sl_sda <= !(sl_respond && sl_rx[7:1] == 7'h39);
         else if (sl_mode == 2 && sl_bits == 8)
            sl_sda <= 1'b0;
         else
            sl_sda <= 1'b1;
      end

      if (RESET_N && sl_prev_scl && SCLO && prev_sdao && !SDAO)
         mon_starts <= mon_starts + 1;
      if (RESET_N && sl_prev_scl && SCLO && !prev_sdao && SDAO)
         mon_stops <= mon_stops + 1;
      if (!END_OK)
         mon_low <= mon_low + 1;
      if (RD_VALID)
         mon_valid <= mon_valid + 1;
      sl_prev_scl  <= SCLO;
      sl_prev_line <= SDAI;
      prev_sdao    <= SDAO;
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic snapshot();
      s_starts = mon_starts;
      s_stops  = mon_stops;
      s_low    = mon_low;
      s_valid  = mon_valid;
      s_ackcnt = mon_ackcnt;
   endtask

   task automatic launch(input logic [7:0] addr, input logic [7:0] ptr, input logic [2:0] bn);
      @(negedge PT_CK);
      SLAVE_ADDRESS = addr;
      REG_ADDR      = ptr;
      BYTE_NUM      = bn;
      GO            = 1'b1;
      @(negedge PT_CK);
      @(negedge PT_CK);
      GO = 1'b0;
      @(negedge PT_CK);
      check_val("launch_st", {24'd0, ST}, 32'd1);
      check_val("launch_busy", {31'd0, END_OK}, 32'd0);
   endtask

   task automatic wait_done();
      for (int i = 0; i < 400 && END_OK !== 1'b1; i++)
         @(negedge PT_CK);
      check_val("done_seen", {31'd0, END_OK}, 32'd1);
   endtask

   task automatic finish_checks(input int exp_ticks, input logic exp_nack, input logic [31:0] exp_data,
                                input int exp_starts, input int exp_acks, input logic [31:0] exp_ackpat);
      logic [31:0] mask;
      check_val("valid_at_done", {31'd0, RD_VALID}, {31'd0, !exp_nack});
      @(negedge PT_CK);
      check_val("valid_drop", {31'd0, RD_VALID}, 32'd0);
      @(negedge PT_CK);
      check_val("busy_ticks", 32'(mon_low - s_low), 32'(exp_ticks));
      check_val("nack_err", {31'd0, NACK_ERR}, {31'd0, exp_nack});
      check_val("rd_data", RD_DATA, exp_data);
      check_val("valid_count", 32'(mon_valid - s_valid), {31'd0, !exp_nack});
      check_val("starts", 32'(mon_starts - s_starts), 32'(exp_starts));
      check_val("stops", 32'(mon_stops - s_stops), 32'd1);
      check_val("ack_count", 32'(mon_ackcnt - s_ackcnt), 32'(exp_acks));
      if (exp_acks > 0) begin
         mask = (32'd1 << exp_acks) - 32'd1;
         check_val("ack_pattern", mon_ackbits & mask, exp_ackpat);
      end
      check_val("idle_st", {24'd0, ST}, 32'd0);
   endtask

   task automatic run_txn(input logic [7:0] addr, input logic [7:0] ptr, input logic [2:0] bn,
                          input int exp_ticks, input logic exp_nack, input logic [31:0] exp_data,
                          input int exp_starts, input int exp_acks, input logic [31:0] exp_ackpat);
      snapshot();
      launch(addr, ptr, bn);
      wait_done();
      finish_checks(exp_ticks, exp_nack, exp_data, exp_starts, exp_acks, exp_ackpat);
   endtask

   initial begin
      RESET_N       = 1'b0;
      GO            = 1'b0;
      SLAVE_ADDRESS = 8'd0;
      REG_ADDR      = 8'd0;
      BYTE_NUM      = 3'd0;
      sl_respond    = 1'b1;
      for (int i = 0; i < 256; i++)
         sl_mem[i] = 8'd0;
      sl_mem[8'h42] = 8'hA5;
      sl_mem[8'h43] = 8'h3C;
      sl_mem[8'h10] = 8'h11;
      sl_mem[8'h11] = 8'h22;
      sl_mem[8'h12] = 8'h33;
      sl_mem[8'h13] = 8'h44;

      repeat (3) @(negedge PT_CK);
      check_val("rst_sdao", {31'd0, SDAO}, 32'd1);
      check_val("rst_sclo", {31'd0, SCLO}, 32'd1);
      check_val("rst_end_ok", {31'd0, END_OK}, 32'd1);
      check_val("rst_nack", {31'd0, NACK_ERR}, 32'd0);
      check_val("rst_valid", {31'd0, RD_VALID}, 32'd0);
      check_val("rst_data", RD_DATA, 32'd0);
      check_val("rst_st", {24'd0, ST}, 32'd0);
      RESET_N = 1'b1;
      repeat (3) @(negedge PT_CK);

      // Two-byte read; address bit 0 set to show it is ignored.
      run_txn(8'h73, 8'h42, 3'd2, 190, 1'b0, 32'h0000A53C, 2, 2, 32'h1);

      // Nobody answers the write address.
      sl_respond = 1'b0;
      run_txn(8'h72, 8'h42, 3'd2, 42, 1'b1, 32'h0, 1, 0, 32'h0);
      sl_respond = 1'b1;

      run_txn(8'h72, 8'h10, 3'd0, 154, 1'b0, 32'h00000011, 2, 1, 32'h1);
      run_txn(8'h72, 8'h10, 3'd7, 262, 1'b0, 32'h11223344, 2, 4, 32'h1);

      // Asynchronous reset in the middle of a transaction.
      launch(8'h72, 8'h42, 3'd2);
      repeat (99) @(negedge PT_CK);
      #2 RESET_N = 1'b0;
      #1;
      check_val("midrst_sdao", {31'd0, SDAO}, 32'd1);
      check_val("midrst_sclo", {31'd0, SCLO}, 32'd1);
      check_val("midrst_end_ok", {31'd0, END_OK}, 32'd1);
      check_val("midrst_st", {24'd0, ST}, 32'd0);
      repeat (3) @(negedge PT_CK);
      RESET_N = 1'b1;
      repeat (2) @(negedge PT_CK);
      run_txn(8'h72, 8'h42, 3'd2, 190, 1'b0, 32'h0000A53C, 2, 2, 32'h1);

      // GO held high through DONE: no relaunch until it falls.
      snapshot();
      launch(8'h72, 8'h42, 3'd2);
      GO = 1'b1;
      wait_done();
      finish_checks(190, 1'b0, 32'h0000A53C, 2, 2, 32'h1);
      repeat (10) @(negedge PT_CK);
      check_val("hold_idle_st", {24'd0, ST}, 32'd0);
      check_val("hold_idle_end_ok", {31'd0, END_OK}, 32'd1);
      snapshot();
      GO = 1'b0;
      @(negedge PT_CK);
      check_val("relaunch_st", {24'd0, ST}, 32'd1);
      wait_done();
      finish_checks(190, 1'b0, 32'h0000A53C, 2, 2, 32'h1);

      // GO pulse while busy is ignored.
      snapshot();
      launch(8'h72, 8'h10, 3'd0);
      repeat (20) @(negedge PT_CK);
      GO = 1'b1;
      @(negedge PT_CK);
      GO = 1'b0;
      wait_done();
      finish_checks(154, 1'b0, 32'h00000011, 2, 1, 32'h1);
      repeat (10) @(negedge PT_CK);
      check_val("pulse_idle_st", {24'd0, ST}, 32'd0);
      check_val("pulse_idle_end_ok", {31'd0, END_OK}, 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
